// File: rtl/switch_input_reader.sv
// switch_input_reader: synchronised, debounced switch/confirm inputs served as memory-mapped CPU loads
module switch_input_reader #(
  parameter int          SW_WIDTH  = 16,
  parameter int          DB_CYCLES = 1000000,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FFF0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SW_WIDTH-1:0] sw_in,
  input  logic                confirm_in,
  input  logic                rd_en,
  input  logic [31:0]         addr,
  output logic [31:0]         rd_data,
  output logic                rd_valid,
  output logic                confirm_pending
);
  localparam int HALF = SW_WIDTH / 2;
  localparam int CW   = $clog2(DB_CYCLES);
  logic [SW_WIDTH-1:0] sw_s1, sw_s2, sw_prev, sw_stable;
  logic [CW-1:0]       sw_cnt, cf_cnt;
  logic                cf_s1, cf_s2, cf_prev, cf_stable;
  logic                sw_inc, sw_take, cf_inc, cf_take, cf_rise;
  logic                pending, overflow, hit, status_rd;
  logic [3:0]          off;
  logic [31:0]         sel;
  // The counter only runs while sync2 differs from stable and held its value last cycle.
  // Taking at DB_CYCLES-2 means stable updates on the edge the count would reach DB_CYCLES-1.
  always_comb begin
    sw_inc    = sw_s2 != sw_stable && sw_s2 == sw_prev;
    sw_take   = sw_inc && sw_cnt == CW'(DB_CYCLES - 2);
    cf_inc    = cf_s2 != cf_stable && cf_s2 == cf_prev;
    cf_take   = cf_inc && cf_cnt == CW'(DB_CYCLES - 2);
    cf_rise   = cf_take && cf_s2;
    off       = addr[3:0] - BASE_ADDR[3:0];
    hit       = addr[31:4] == BASE_ADDR[31:4] && off[0] && off <= 4'hB;
    status_rd = rd_en && hit && off == 4'hB;
    sel = off == 4'h1 ? 32'(sw_stable) :
          off == 4'h3 ? 32'($signed(sw_stable[SW_WIDTH-1:HALF])) :
          off == 4'h5 ? 32'(sw_stable[SW_WIDTH-1:HALF]) :
          off == 4'h7 ? 32'(sw_stable[2:0]) :
          off == 4'h9 ? 32'(sw_stable[HALF-1:0]) :
                        {30'd0, overflow, pending};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1     <= '0;
      sw_s2     <= '0;
      sw_prev   <= '0;
      sw_stable <= '0;
      sw_cnt    <= '0;
      cf_s1     <= 1'b0;
      cf_s2     <= 1'b0;
      cf_prev   <= 1'b0;
      cf_stable <= 1'b0;
      cf_cnt    <= '0;
      pending   <= 1'b0;
      overflow  <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      sw_s1     <= sw_in;
      sw_s2     <= sw_s1;
      sw_prev   <= sw_s2;
      sw_cnt    <= sw_inc && !sw_take ? sw_cnt + 1'b1 : '0;
      sw_stable <= sw_take ? sw_s2 : sw_stable;
      cf_s1     <= confirm_in;
      cf_s2     <= cf_s1;
      cf_prev   <= cf_s2;
      cf_cnt    <= cf_inc && !cf_take ? cf_cnt + 1'b1 : '0;
      cf_stable <= cf_take ? cf_s2 : cf_stable;
      // A status read returns the pre-edge value; a press landing on the same edge survives the clear.
      pending   <= status_rd ? cf_rise : pending | cf_rise;
      overflow  <= status_rd ? 1'b0 : overflow | (cf_rise & pending);
      rd_valid  <= rd_en && hit;
      rd_data   <= rd_en && hit ? sel : rd_data;
    end
  end
  assign confirm_pending = pending;
endmodule

// File: tb/tb_switch_input_reader.sv
// tb_switch_input_reader: table-driven and directed checks of the switch/confirm IO unit
module tb_switch_input_reader;
  logic        clk, rst, confirm_in, rd_en, rd_valid, confirm_pending;
  logic [15:0] sw_in;
  logic [31:0] addr, rd_data;
  int checks = 0, failures = 0;
  typedef struct { logic [31:0] a; logic [31:0] d; logic v; } vec_t;
  vec_t vt[9];
  switch_input_reader #(.SW_WIDTH(16), .DB_CYCLES(4), .BASE_ADDR(32'hFFFF_FFF0)) dut (
    .clk(clk), .rst(rst), .sw_in(sw_in), .confirm_in(confirm_in), .rd_en(rd_en),
    .addr(addr), .rd_data(rd_data), .rd_valid(rd_valid), .confirm_pending(confirm_pending)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic rd(input logic [31:0] a);
    addr  = a;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask
  task automatic press();
    confirm_in = 1'b1;
    ticks(8);
    confirm_in = 1'b0;
    ticks(8);
  endtask
  initial begin
    rst = 1'b1; sw_in = '0; confirm_in = 1'b0; rd_en = 1'b0; addr = '0;
    ticks(3);
    check("reset_rd_data", rd_data, 32'h0);
    check("reset_rd_valid", {31'd0, rd_valid}, 32'h0);
    check("reset_pending", {31'd0, confirm_pending}, 32'h0);
    rst = 1'b0;
    rd(32'hFFFF_FFF1);
    check("first_read_data", rd_data, 32'h0);
    check("first_read_valid", {31'd0, rd_valid}, 32'h1);
    tick();
    check("valid_single_pulse", {31'd0, rd_valid}, 32'h0);
    rd(32'hFFFF_FFF2);
    check("miss_valid", {31'd0, rd_valid}, 32'h0);
    check("miss_data", rd_data, 32'h0);
    vt[0] = '{32'hFFFF_FFF1, 32'h0000_A53C, 1'b1};
    vt[1] = '{32'hFFFF_FFF3, 32'hFFFF_FFA5, 1'b1};
    vt[2] = '{32'hFFFF_FFF5, 32'h0000_00A5, 1'b1};
    vt[3] = '{32'hFFFF_FFF7, 32'h0000_0004, 1'b1};
    vt[4] = '{32'hFFFF_FFF9, 32'h0000_003C, 1'b1};
    vt[5] = '{32'hFFFF_FFF2, 32'h0000_003C, 1'b0};
    vt[6] = '{32'hFFFF_FFFB, 32'h0000_0000, 1'b1};
    vt[7] = '{32'hFFFF_FFE1, 32'h0000_0000, 1'b0};
    vt[8] = '{32'hFFFF_FFFD, 32'h0000_0000, 1'b0};
    sw_in = 16'hA53C;
    ticks(10);
    for (int i = 0; i < 9; i++) begin
      rd(vt[i].a);
      check($sformatf("vec%0d_data", i), rd_data, vt[i].d);
      check($sformatf("vec%0d_valid", i), {31'd0, rd_valid}, {31'd0, vt[i].v});
    end
    sw_in = 16'h0000;
    ticks(10);
    sw_in = 16'hFFFF;
    ticks(3);
    sw_in = 16'h0000;
    ticks(10);
    rd(32'hFFFF_FFF1);
    check("glitch_filtered", rd_data, 32'h0);
    sw_in = 16'hFFFF;
    ticks(4);
    addr = 32'hFFFF_FFF1;
    rd_en = 1'b1;
    tick();
    check("latency_edge4", rd_data, 32'h0);
    tick();
    check("latency_edge5", rd_data, 32'h0);
    tick();
    check("latency_edge6", rd_data, 32'h0000_FFFF);
    check("b2b_valid", {31'd0, rd_valid}, 32'h1);
    rd_en = 1'b0;
    press();
    press();
    check("two_press_pending", {31'd0, confirm_pending}, 32'h1);
    rd(32'hFFFF_FFF1);
    check("nonstatus_read_keeps_pending", {31'd0, confirm_pending}, 32'h1);
    rd(32'hFFFF_FFFB);
    check("status_overflow", rd_data, 32'h3);
    check("status_clear_pending", {31'd0, confirm_pending}, 32'h0);
    rd(32'hFFFF_FFFB);
    check("status_second_read", rd_data, 32'h0);
    confirm_in = 1'b1;
    ticks(5);
    rd(32'hFFFF_FFFB);
    check("same_edge_read", rd_data, 32'h0);
    check("same_edge_pending", {31'd0, confirm_pending}, 32'h1);
    ticks(8);
    confirm_in = 1'b0;
    ticks(8);
    rd(32'hFFFF_FFFB);
    check("same_edge_next_read", rd_data, 32'h1);
    check("same_edge_cleared", {31'd0, confirm_pending}, 32'h0);
    confirm_in = 1'b1;
    ticks(5);
    rst = 1'b1;
    rd_en = 1'b1;
    addr = 32'hFFFF_FFF1;
    tick();
    check("midpress_rst_data", rd_data, 32'h0);
    check("midpress_rst_valid", {31'd0, rd_valid}, 32'h0);
    check("midpress_rst_pending", {31'd0, confirm_pending}, 32'h0);
    rst = 1'b0;
    tick();
    rd_en = 1'b0;
    check("post_rst_stable_cleared", rd_data, 32'h0);
    check("post_rst_valid", {31'd0, rd_valid}, 32'h1);
    ticks(4);
    check("post_rst_not_yet", {31'd0, confirm_pending}, 32'h0);
    tick();
    check("post_rst_press_seen", {31'd0, confirm_pending}, 32'h1);
    confirm_in = 1'b0;
    ticks(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/switch_input_reader.md
# switch_input_reader

Parametrised memory-mapped input unit for the board switches and the confirm button. Synchronises and debounces a SW_WIDTH-bit switch bank plus one confirm button, and serves CPU loads from the IO address window in several extraction modes. Latches confirm presses into a sticky status register so a press is never missed between polls. Sits between the board pins and the CPU load path, alongside the LED and segment output units.

## Interface

Parameters:

- SW_WIDTH, 16, switch bank width; even, 8..32. HALF = SW_WIDTH/2.
- DB_CYCLES, 1000000, cycles a new input level must be stable before it is accepted; >= 2.
- BASE_ADDR, 32'hFFFF_FFF0, base of the 16-byte IO window.

Ports:

- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- sw_in  input  SW_WIDTH  raw switch pins, asynchronous.
- confirm_in  input  1  raw confirm button, asynchronous, active-high.
- rd_en  input  1  CPU load strobe, one cycle per access.
- addr  input  32  load address.
- rd_data  output  32  load data, registered.
- rd_valid  output  1  one-cycle pulse: rd_data is valid for an address hit.
- confirm_pending  output  1  level copy of status bit 0, for the interrupt/LED path.

## Operation

- Synchronisation: each of sw_in and confirm_in passes through a 2-flop synchroniser (sync1 -> sync2).
- Debounce: two independent channels, one for the whole switch vector and one for confirm. Each has a stable register, a previous-sample register and a counter of width clog2(DB_CYCLES).
  - The counter clears when sync2 equals stable, or when sync2 differs from its previous-cycle value.
  - Otherwise it increments.
  - When the counter reaches DB_CYCLES-1 while incrementing, stable takes sync2 and the counter clears.
- Confirm edge: a debounced confirm rising edge (stable goes 0->1) sets status.pending.
  - If pending is already 1 at that edge, status.overflow is also set.
- Address map, offset = addr - BASE_ADDR; a hit requires addr[31:4] == BASE_ADDR[31:4] and one of the offsets below:
  - 0x1: zero-extend the full stable switch vector.
  - 0x3: sign-extend the high half, sw[SW_WIDTH-1:HALF], using bit SW_WIDTH-1.
  - 0x5: zero-extend the high half.
  - 0x7: zero-extend sw[2:0] (test-case number).
  - 0x9: zero-extend the low half, sw[HALF-1:0].
  - 0xB: status. Bit 0 = pending, bit 1 = overflow, bits 2 and up = 0. The read clears both bits.
- Hit with rd_en: rd_data loads the selected value on the next edge and rd_valid pulses for 1 cycle.
- Miss, or rd_en = 0: rd_valid = 0 and rd_data holds its previous value. A miss has no side effects.
- Simultaneous status read and confirm edge: the read returns the pre-edge status.
  - Afterwards pending = 1 (the new press is kept) and overflow = 0.
- A read of any non-status offset never alters status.

## Timing

- Reset, all registers: rd_data = 0, rd_valid = 0, confirm_pending = 0, status = 0, stable values = 0, counters = 0, synchronisers = 0.
  - Reset mid-debounce discards the partial count.
  - Reset overrides a same-cycle rd_en.
- Load latency is 1 cycle: rd_en/addr sampled at edge N gives rd_data/rd_valid valid after edge N.
  - rd_en may be asserted on consecutive cycles; each hit is served independently.
- Input-to-stable latency: a clean level change present before edge 0 reaches sync2 after edge 1 and stable after edge 1+DB_CYCLES.
- Glitch filter: a pulse shorter than DB_CYCLES cycles at sync2 never changes stable.
- confirm_pending follows status.pending in the same cycle; both change on the same edge as status.
- rd_data reflects the stable values in the cycle rd_en is sampled. It is not updated later even if the inputs change.

## Test plan

- Sim parameters DB_CYCLES = 4, SW_WIDTH = 16. Reset, then read offset 0x1 -> rd_data = 0, rd_valid pulses once. Read addr 0xFFFF_FFF2 -> rd_valid stays 0 and rd_data holds 0.
- sw_in = 16'hA53C held for 10 cycles, then read each mode:
  - 0x1 -> 0x0000_A53C
  - 0x3 -> 0xFFFF_FFA5
  - 0x5 -> 0x0000_00A5
  - 0x7 -> 0x0000_0004
  - 0x9 -> 0x0000_003C
- Switch glitch 16'h0000 -> 16'hFFFF for 3 cycles, then back -> offset 0x1 still reads 0. The same change held 4+ cycles is visible exactly 5 edges after the change reaches the synchroniser input edge (1 + DB_CYCLES).
- Two debounced confirm presses with no read in between -> confirm_pending = 1. Read 0xB -> 0x0000_0003. A second read of 0xB -> 0x0000_0000 and confirm_pending = 0.
- Status read on the same edge as a debounced confirm rise -> that read returns 0x0. The next read of 0xB returns 0x1.
- Assert rst during a press while the debounce counter = 2 -> all outputs 0 on the next edge. The press is registered only if it is held a further 1 + DB_CYCLES edges after reset is released.
